// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-port BRAM arbiter: FSM state encoding and
// default widths / burst limit.
package bram_arb_pkg;

    localparam int unsigned ADDR_W_DEF    = 9;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned BURST_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bram_arb_rr.sv
// Priority pointer and burst counter for bram_arbiter.
// Optional feature macro: BRAM_ARB_ROUND_ROBIN_EN. When it is undefined the
// pointer is fixed on requester 0 and no burst counter exists.
module bram_arb_rr
    import bram_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_access,      // counted access in the current grant
    input  logic i_state_chg,   // FSM changes state on this edge
    input  logic i_enter_0,     // FSM enters GNT0 on this edge
    input  logic i_enter_1,     // FSM enters GNT1 on this edge
    output logic o_prio_1,      // 1: requester 1 wins a tie from IDLE
    output logic o_burst_done   // burst limit reached, including this access
);

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    localparam int unsigned CntW = $clog2(BURST_MAX + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(BURST_MAX);
    localparam logic [CntW-1:0] CntLast = CntW'(BURST_MAX - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_prio_1;

    // Burst counter: clears on any state change, saturates at BURST_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_state_chg) begin
            r_cnt <= '0;
        end else if (i_access && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    // Priority pointer: favour whoever was not granted most recently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio_1 <= 1'b0;
        end else if (i_enter_0) begin
            r_prio_1 <= 1'b1;
        end else if (i_enter_1) begin
            r_prio_1 <= 1'b0;
        end
    end

    assign o_prio_1 = r_prio_1;
    // Look ahead by the current access so exactly BURST_MAX accesses are granted.
    assign o_burst_done = (r_cnt == CntMax) || (i_access && (r_cnt == CntLast));
`else
    logic w_unused;
    assign w_unused = ^{clk, reset_n, i_access, i_state_chg, i_enter_0, i_enter_1,
                        BURST_MAX[0]};

    assign o_prio_1     = 1'b0;
    assign o_burst_done = 1'b0;
`endif

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for a single BRAM port with registered grants and
// per-requester read-valid tagging.
// Optional feature macro: BRAM_ARB_ROUND_ROBIN_EN (round-robin tie break and
// burst limiting); default build gives fixed priority to requester 0 and
// holds a grant until its request drops.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] din_0,
    input  logic [DATA_W-1:0] din_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    arb_state_t r_state;
    arb_state_t w_state_d;
    logic       r_gnt_0;
    logic       r_gnt_1;
    logic       r_rvalid_0;
    logic       r_rvalid_1;
    logic       w_acc_0;
    logic       w_acc_1;
    logic       w_prio_1;
    logic       w_burst_done;
    logic       w_state_chg;
    logic       w_enter_0;
    logic       w_enter_1;

    assign w_acc_0     = r_gnt_0 & req_0;
    assign w_acc_1     = r_gnt_1 & req_1;
    assign w_state_chg = (w_state_d != r_state);
    assign w_enter_0   = w_state_chg && (w_state_d == GNT0);
    assign w_enter_1   = w_state_chg && (w_state_d == GNT1);

    bram_arb_rr #(
        .BURST_MAX (BURST_MAX)
    ) u_rr (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_access     (w_acc_0 | w_acc_1),
        .i_state_chg  (w_state_chg),
        .i_enter_0    (w_enter_0),
        .i_enter_1    (w_enter_1),
        .o_prio_1     (w_prio_1),
        .o_burst_done (w_burst_done)
    );

    // Next-state decision shared by the FSM and the pointer/counter block.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: begin
                if (req_0 && (!req_1 || !w_prio_1)) begin
                    w_state_d = GNT0;
                end else if (req_1) begin
                    w_state_d = GNT1;
                end
            end
            GNT0: begin
                if (!req_0) begin
                    w_state_d = req_1 ? GNT1 : IDLE;
                end else if (w_burst_done && req_1) begin
                    w_state_d = GNT1;
                end
            end
            GNT1: begin
                if (!req_1) begin
                    w_state_d = req_0 ? GNT0 : IDLE;
                end else if (w_burst_done && req_0) begin
                    w_state_d = GNT0;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Grant FSM with registered grant outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_gnt_0 <= 1'b0;
            r_gnt_1 <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_gnt_0 <= (w_state_d == GNT0);
            r_gnt_1 <= (w_state_d == GNT1);
        end
    end

    // Read-valid tags follow the requester that issued the read, even across a handoff.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid_0 <= 1'b0;
            r_rvalid_1 <= 1'b0;
        end else begin
            r_rvalid_0 <= w_acc_0 & ~we_0;
            r_rvalid_1 <= w_acc_1 & ~we_1;
        end
    end

    // BRAM port mux driven only by a counted access.
    always_comb begin
        mem_en   = w_acc_0 | w_acc_1;
        mem_we   = 1'b0;
        mem_addr = addr_0;
        mem_din  = din_0;
        if (w_acc_1) begin
            mem_we   = we_1;
            mem_addr = addr_1;
            mem_din  = din_1;
        end else if (w_acc_0) begin
            mem_we = we_0;
        end
    end

    assign gnt_0    = r_gnt_0;
    assign gnt_1    = r_gnt_1;
    assign rvalid_0 = r_rvalid_0;
    assign rvalid_1 = r_rvalid_1;
    assign rdata_0  = mem_dout;
    assign rdata_1  = mem_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural one-cycle-latency BRAM.
module tb_bram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req_0, req_1, we_0, we_1;
    logic [8:0]  addr_0, addr_1;
    logic [15:0] din_0, din_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [15:0] rdata_0, rdata_1;
    logic        mem_en, mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    int checks;
    int failures;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    bram_arbiter u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_0    (req_0),
        .req_1    (req_1),
        .we_0     (we_0),
        .we_1     (we_1),
        .addr_0   (addr_0),
        .addr_1   (addr_1),
        .din_0    (din_0),
        .din_1    (din_1),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .rvalid_0 (rvalid_0),
        .rvalid_1 (rvalid_1),
        .rdata_0  (rdata_0),
        .rdata_1  (rdata_1),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural BRAM: unwritten words hold 16'h1000+addr, except word 5 = 16'h00AA.
    bit   [15:0] mem_w [512];
    bit          wr_flag [512];
    logic [15:0] dout_r;

    function automatic logic [15:0] mem_rd(input logic [8:0] a);
        if (wr_flag[a]) return mem_w[a];
        if (a == 9'd5) return 16'h00AA;
        return 16'h1000 + {7'd0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_w[mem_addr]   <= mem_din;
                wr_flag[mem_addr] <= 1'b1;
            end else begin
                dout_r <= mem_rd(mem_addr);
            end
        end
    end
    assign mem_dout = dout_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("gnt_exclusive", {31'd0, gnt_0 & gnt_1}, 32'd0);
                if (rvalid_0) begin
                    chk("rvalid_0_expected", {31'd0, q0.size() != 0}, 32'd1);
                    if (q0.size() != 0) begin
                        e = q0.pop_front();
                        chk("rdata_0", {16'd0, rdata_0}, {16'd0, e});
                    end
                end
                if (rvalid_1) begin
                    chk("rvalid_1_expected", {31'd0, q1.size() != 0}, 32'd1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        chk("rdata_1", {16'd0, rdata_1}, {16'd0, e});
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
        addr_0 = '0;  addr_1 = '0;  din_0 = '0;  din_1 = '0;
        fork
            monitor();
        join_none

        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_gnt_0", {31'd0, gnt_0}, 32'd0);
        chk("rst_gnt_1", {31'd0, gnt_1}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid_0, rvalid_1}, 32'd0);
        chk("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single read of word 5.
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 9'd5;
        @(negedge clk);
        chk("rd_gnt_not_yet", {31'd0, gnt_0}, 32'd0);
        chk("rd_mem_en_idle", {31'd0, mem_en}, 32'd0);
        tick();
        chk("rd_gnt_0", {31'd0, gnt_0}, 32'd1);
        chk("rd_mem_en", {31'd0, mem_en}, 32'd1);
        chk("rd_mem_addr", {23'd0, mem_addr}, 32'd5);
        q0.push_back(16'h00AA);
        tick();
        req_0 = 1'b0;
        chk("rd_rvalid_0", {31'd0, rvalid_0}, 32'd1);
        tick();
        chk("rd_rvalid_0_pulse", {31'd0, rvalid_0}, 32'd0);
        chk("rd_gnt_release", {31'd0, gnt_0}, 32'd0);

        // Requester 1 writes 32 to word 1, then requester 0 reads it back.
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 9'd1; din_1 = 16'd32;
        tick();
        chk("wr_gnt_1", {31'd0, gnt_1}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        tick();
        req_1 = 1'b0; we_1 = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 9'd1;
        chk("wr_no_rvalid_1", {31'd0, rvalid_1}, 32'd0);
        tick();
        chk("wr_rd_gnt_0", {31'd0, gnt_0}, 32'd1);
        q0.push_back(16'd32);
        tick();
        req_0 = 1'b0;
        chk("wr_rd_rvalid_0", {31'd0, rvalid_0}, 32'd1);
        tick();
        tick();

        // Simultaneous reads after reset; last GNT0 read targets word 3.
        do_reset();
        req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b0; we_1 = 1'b0;
        addr_0 = 9'd0; addr_1 = 9'd1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            chk("sim_gnt_0_hold", {30'd0, gnt_0, gnt_1}, 32'd2);
            if (k == 8) begin
                addr_0 = 9'd3;
                q0.push_back(16'h1003);
            end else begin
                q0.push_back(16'h1000);
            end
            tick();
        end
        req_0 = 1'b0;
        chk("ho_rvalid_0", {31'd0, rvalid_0}, 32'd1);
        chk("ho_rvalid_1_quiet", {31'd0, rvalid_1}, 32'd0);
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        chk("ho_gnt_1", {30'd0, gnt_0, gnt_1}, 32'd1);
        q1.push_back(16'd32);
        tick();
`else
        chk("fp_gnt_0_held", {30'd0, gnt_0, gnt_1}, 32'd2);
        tick();
        chk("fp_gnt_1", {30'd0, gnt_0, gnt_1}, 32'd1);
        chk("fp_no_rvalid_0", {31'd0, rvalid_0}, 32'd0);
        q1.push_back(16'd32);
        tick();
`endif
        req_1 = 1'b0;
        chk("ho_rvalid_1", {31'd0, rvalid_1}, 32'd1);
        tick();
        tick();
        chk("ho_idle", {30'd0, gnt_0, gnt_1}, 32'd0);

        // Reset during GNT1 with a read in flight.
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 9'd2;
        tick();
        chk("mr_gnt_1", {31'd0, gnt_1}, 32'd1);
        chk("mr_mem_en", {31'd0, mem_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mr_gnt_clear", {30'd0, gnt_0, gnt_1}, 32'd0);
        chk("mr_mem_clear", {30'd0, mem_en, mem_we}, 32'd0);
        chk("mr_rvalid_clear", {30'd0, rvalid_0, rvalid_1}, 32'd0);
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 9'd5;
        tick();
        chk("mr_rvalid_dropped", {31'd0, rvalid_1}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("mr_gnt_0_first", {30'd0, gnt_0, gnt_1}, 32'd2);
        q0.push_back(16'h00AA);
        tick();
        req_0 = 1'b0; req_1 = 1'b0;
        chk("mr_rvalid_0", {31'd0, rvalid_0}, 32'd1);
        tick();
        tick();
        tick();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 9, as the BRAM word address width (512 words).
REQ-002 The block SHALL provide parameter DATA_W, default 16, as the BRAM data width.
REQ-003 The block SHALL provide parameter BURST_MAX, default 8, as the maximum number of consecutive granted accesses before a forced handoff.
REQ-004 clk  input  1  the single system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_0, req_1  input  1 each  requester N wants the memory port this cycle.
REQ-007 we_0, we_1  input  1 each  requester N access is a write (1) or a read (0).
REQ-008 addr_0, addr_1  input  ADDR_W each  requester N word address.
REQ-009 din_0, din_1  input  DATA_W each  requester N write data.
REQ-010 gnt_0, gnt_1  output  1 each  registered grant to requester N; never both 1.
REQ-011 rvalid_0, rvalid_1  output  1 each  read data for requester N is valid this cycle.
REQ-012 rdata_0, rdata_1  output  DATA_W each  read data returned to requester N.
REQ-013 mem_en, mem_we  output  1 each  enable and write-enable to the BRAM port.
REQ-014 mem_addr, mem_din  output  ADDR_W, DATA_W  address and write data to the BRAM port.
REQ-015 mem_dout  input  DATA_W  BRAM port read data, valid one clock after an enabled read.

Function
REQ-016 The FSM SHALL have states IDLE, GNT0 and GNT1; gnt_N SHALL be 1 exactly in state GNTN.
REQ-017 From IDLE with exactly one req_N high, the FSM SHALL enter GNTN on the next edge.
REQ-018 From IDLE with both requests high, the FSM SHALL grant the requester not granted most recently; the post-reset priority pointer SHALL favour requester 0.
REQ-019 In GNTN with req_N high, the block SHALL combinationally drive mem_en=1, mem_we=we_N, mem_addr=addr_N and mem_din=din_N; an access counts only when gnt_N and req_N are both 1.
REQ-020 In any other cycle, mem_en and mem_we SHALL be 0.
REQ-021 In GNTN, a burst counter SHALL increment on each counted access and clear on every state change.
REQ-022 In GNTN, if req_N drops, the FSM SHALL go to GNT(other) when the other requester is requesting, else to IDLE.
REQ-023 In GNTN, when the counter reaches BURST_MAX and the other requester is requesting, the FSM SHALL hand off to GNT(other); with no competing request, the grant SHALL continue and the counter SHALL saturate.
REQ-024 rvalid_N SHALL be a one-cycle registered pulse exactly one clock after a counted read by requester N.
REQ-025 rdata_N SHALL equal mem_dout continuously and is meaningful only while rvalid_N is 1.
REQ-026 A write SHALL produce no rvalid pulse.
REQ-027 A read issued in the last granted cycle before a handoff SHALL still return its rvalid to the original requester.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, the burst counter to 0, the priority pointer to requester 0, and gnt_N, rvalid_N, mem_en and mem_we to 0.
REQ-029 Reset asserted mid-burst SHALL drop any pending rvalid.

Configuration
REQ-030 With macro BRAM_ARB_ROUND_ROBIN_EN defined, REQ-018 round-robin and REQ-023 burst limiting SHALL apply.
REQ-031 Without BRAM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests, the burst counter SHALL be omitted, and a grant SHALL be held until its request drops.

Structure
REQ-032 A shared package bram_arb_pkg SHALL hold the FSM state encoding, ADDR_W/DATA_W defaults and the BURST_MAX default.
REQ-033 The priority pointer plus burst counter SHALL be a sub-module named bram_arb_rr.

Verification
REQ-034 Single read: req_0=1, we_0=0, addr_0=5, memory[5]=16'h00AA -> gnt_0 rises one cycle later; rvalid_0=1 with rdata_0=16'h00AA one cycle after the granted access.
REQ-035 Simultaneous reads after reset: req_0=req_1=1, addr_0=0, addr_1=1 -> GNT0 first; after 8 accesses, handoff to GNT1; gnt_0 and gnt_1 are never 1 together.
REQ-036 Write then read: requester 1 writes 16'd32 to address 1, then requester 0 reads address 1 -> rdata_0=16'd32 with rvalid_0=1 and no rvalid_1 pulse.
REQ-037 Handoff read: requester 0 reads address 3 in its last granted cycle before handoff -> rvalid_0 pulses in the first GNT1 cycle and rvalid_1 stays 0.
REQ-038 Reset mid-burst: reset_n low during GNT1 with a read pending -> all outputs 0 that cycle; after release with req_0=req_1=1, GNT0 is granted first.
